// File: rtl/demux_dispatch_pkg.sv
// Shared defaults and slot state encoding for the demux dispatcher.
package demux_dispatch_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned SEL_W_DEF  = 2;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_dispatch_slot.sv
// One-entry output slot with valid/ready handshake; loads on strobe, reloads without a bubble.
module demux_dispatch_slot
    import demux_dispatch_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    slot_state_e       state_q;
    slot_state_e       state_d;
    logic [DATA_W-1:0] data_q;

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill on load, drain on ready unless reloaded in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL:  if (!load && ready) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // Payload register; only written on load so it stays stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    assign valid = (state_q == SLOT_FULL);
    assign data  = data_q;

endmodule

// File: rtl/demux_dispatch.sv
// 1-to-NUM_CH dispatcher: routes accepted words by explicit select or round-robin pointer.
module demux_dispatch
    import demux_dispatch_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned SEL_W  = SEL_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     rr_mode,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]         rr_ptr,
    output logic [CNT_W-1:0]         acc_cnt
);

    logic [SEL_W-1:0] dst_c;
    logic             accept_c;

    // Destination and acceptance; a stalled destination blocks input with no skip-ahead.
    always_comb begin
        dst_c    = rr_mode ? rr_ptr : in_sel;
        in_ready = !out_valid[dst_c] || out_ready[dst_c];
        accept_c = in_valid && in_ready;
    end

    // One slot per channel; only the destination slot may load in a cycle.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_dispatch_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (accept_c && (dst_c == SEL_W'(k))),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*DATA_W +: DATA_W])
        );
    end

    // Round-robin pointer advances only on accepts made in rr mode; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept_c && rr_mode) begin
            rr_ptr <= rr_ptr + SEL_W'(1);
        end
    end

    // Accepted-word counter, wraps at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
        end else if (accept_c) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux_dispatch.sv
// Self-checking bench for demux_dispatch: directed vector table, async reset, randomized model check.
module tb_demux_dispatch;

    localparam int unsigned DW = 8;
    localparam int unsigned NC = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned CW = 16;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [SW-1:0]  in_sel;
    logic           rr_mode;
    logic [NC-1:0]  out_valid;
    logic [NC-1:0]  out_ready;
    logic [NC*DW-1:0] out_data;
    logic [SW-1:0]  rr_ptr;
    logic [CW-1:0]  acc_cnt;

    int checks   = 0;
    int failures = 0;

    demux_dispatch #(.DATA_W(DW), .NUM_CH(NC), .SEL_W(SW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .rr_mode   (rr_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr),
        .acc_cnt   (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        rr;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        e_rdy;
        logic [3:0]  e_val;
        logic [1:0]  e_rr;
        logic [15:0] e_cnt;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[23];

    // Reference model state for the random phase.
    bit       m_full[NC];
    bit [7:0] m_data[NC];
    int       m_rr;
    int       m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs just after an edge, sample in_ready mid-cycle, then advance past the next edge.
    task automatic cycle(input logic v, input logic [1:0] sel, input logic rr, input logic [7:0] d,
                         input logic [3:0] ordy, output logic rdy);
        in_valid  = v;
        in_sel    = sel;
        rr_mode   = rr;
        in_data   = d;
        out_ready = ordy;
        #3;
        rdy = in_ready;
        @(posedge clk);
        #1;
    endtask

    logic rdy;

    initial begin
        // Directed sequence from reset: route, backpressure, round robin, rr stall, mode toggle.
        tbl[0]  = '{1'b1, 2'd3, 1'b0, 8'hA5, 4'b1111, 1'b1, 4'b1000, 2'd0, 16'd1,  32'hA5000000};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd0, 16'd1,  32'hA5000000};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 8'h11, 4'b1101, 1'b1, 4'b0010, 2'd0, 16'd2,  32'hA5001100};
        tbl[3]  = '{1'b1, 2'd1, 1'b0, 8'h22, 4'b1101, 1'b0, 4'b0010, 2'd0, 16'd2,  32'hA5001100};
        tbl[4]  = '{1'b1, 2'd1, 1'b0, 8'h22, 4'b1111, 1'b1, 4'b0010, 2'd0, 16'd3,  32'hA5002200};
        tbl[5]  = '{1'b0, 2'd1, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd0, 16'd3,  32'hA5002200};
        tbl[6]  = '{1'b1, 2'd0, 1'b1, 8'h01, 4'b1111, 1'b1, 4'b0001, 2'd1, 16'd4,  32'hA5002201};
        tbl[7]  = '{1'b1, 2'd0, 1'b1, 8'h02, 4'b1111, 1'b1, 4'b0010, 2'd2, 16'd5,  32'hA5000201};
        tbl[8]  = '{1'b1, 2'd0, 1'b1, 8'h03, 4'b1111, 1'b1, 4'b0100, 2'd3, 16'd6,  32'hA5030201};
        tbl[9]  = '{1'b1, 2'd0, 1'b1, 8'h04, 4'b1111, 1'b1, 4'b1000, 2'd0, 16'd7,  32'h04030201};
        tbl[10] = '{1'b1, 2'd0, 1'b1, 8'h05, 4'b1111, 1'b1, 4'b0001, 2'd1, 16'd8,  32'h04030205};
        tbl[11] = '{1'b1, 2'd0, 1'b1, 8'h06, 4'b1111, 1'b1, 4'b0010, 2'd2, 16'd9,  32'h04030605};
        tbl[12] = '{1'b1, 2'd0, 1'b1, 8'h07, 4'b1101, 1'b1, 4'b0110, 2'd3, 16'd10, 32'h04070605};
        tbl[13] = '{1'b1, 2'd0, 1'b1, 8'h08, 4'b1101, 1'b1, 4'b1010, 2'd0, 16'd11, 32'h08070605};
        tbl[14] = '{1'b1, 2'd0, 1'b1, 8'h09, 4'b1101, 1'b1, 4'b0011, 2'd1, 16'd12, 32'h08070609};
        tbl[15] = '{1'b1, 2'd0, 1'b1, 8'h0A, 4'b1101, 1'b0, 4'b0010, 2'd1, 16'd12, 32'h08070609};
        tbl[16] = '{1'b1, 2'd0, 1'b1, 8'h0A, 4'b1101, 1'b0, 4'b0010, 2'd1, 16'd12, 32'h08070609};
        tbl[17] = '{1'b1, 2'd0, 1'b1, 8'h0A, 4'b1111, 1'b1, 4'b0010, 2'd2, 16'd13, 32'h08070A09};
        tbl[18] = '{1'b1, 2'd0, 1'b1, 8'h0B, 4'b1111, 1'b1, 4'b0100, 2'd3, 16'd14, 32'h080B0A09};
        tbl[19] = '{1'b1, 2'd0, 1'b0, 8'h0C, 4'b1111, 1'b1, 4'b0001, 2'd3, 16'd15, 32'h080B0A0C};
        tbl[20] = '{1'b1, 2'd0, 1'b0, 8'h0D, 4'b1111, 1'b1, 4'b0001, 2'd3, 16'd16, 32'h080B0A0D};
        tbl[21] = '{1'b1, 2'd0, 1'b1, 8'h0E, 4'b1111, 1'b1, 4'b1000, 2'd0, 16'd17, 32'h0E0B0A0D};
        tbl[22] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd0, 16'd17, 32'h0E0B0A0D};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        rr_mode   = 1'b0;
        out_ready = '0;
        #12;
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_rr",    32'(rr_ptr),    32'h0);
        chk("reset_cnt",   32'(acc_cnt),   32'h0);
        chk("reset_data",  out_data,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            cycle(tbl[i].v, tbl[i].sel, tbl[i].rr, tbl[i].d, tbl[i].ordy, rdy);
            chk($sformatf("vec%0d_in_ready", i),  32'(rdy),       32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_val));
            chk($sformatf("vec%0d_rr_ptr", i),    32'(rr_ptr),    32'(tbl[i].e_rr));
            chk($sformatf("vec%0d_acc_cnt", i),   32'(acc_cnt),   32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_out_data", i),  out_data,       tbl[i].e_data);
        end

        // Mid-stream async reset: rr_ptr moved, slot 2 held full under backpressure.
        cycle(1'b1, 2'd0, 1'b1, 8'h33, 4'b0000, rdy);
        cycle(1'b1, 2'd2, 1'b0, 8'h5A, 4'b0000, rdy);
        chk("pre_reset_valid", 32'(out_valid), 32'h5);
        chk("pre_reset_rr",    32'(rr_ptr),    32'h1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'h0);
        chk("async_reset_rr",    32'(rr_ptr),    32'h0);
        chk("async_reset_cnt",   32'(acc_cnt),   32'h0);
        chk("async_reset_data",  out_data,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the behavioural model.
        for (int k = 0; k < NC; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = 8'h00;
        end
        m_rr  = 0;
        m_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            logic       v;
            logic [1:0] sel;
            logic       rr;
            logic [7:0] d;
            logic [3:0] ordy;
            int         dst;
            bit         exp_rdy;
            logic [31:0] exp_data;
            logic [3:0]  exp_val;
            v    = 1'($urandom_range(0, 3) != 0);
            sel  = 2'($urandom);
            rr   = 1'($urandom);
            d    = 8'($urandom);
            ordy = 4'($urandom) | 4'($urandom);
            dst  = rr ? m_rr : int'(sel);
            exp_rdy = !m_full[dst] || ordy[dst];
            cycle(v, sel, rr, d, ordy, rdy);
            chk($sformatf("rnd%0d_in_ready", n), 32'(rdy), 32'(exp_rdy));
            for (int k = 0; k < NC; k++) begin
                if (m_full[k] && ordy[k]) m_full[k] = 1'b0;
            end
            if (v && exp_rdy) begin
                m_full[dst] = 1'b1;
                m_data[dst] = d;
                m_cnt = (m_cnt + 1) % 65536;
                if (rr) m_rr = (m_rr + 1) % NC;
            end
            for (int k = 0; k < NC; k++) begin
                exp_val[k]          = m_full[k];
                exp_data[k*8 +: 8]  = m_data[k];
            end
            chk($sformatf("rnd%0d_out_valid", n), 32'(out_valid), 32'(exp_val));
            chk($sformatf("rnd%0d_out_data", n),  out_data,       exp_data);
            chk($sformatf("rnd%0d_rr_ptr", n),    32'(rr_ptr),    32'(m_rr));
            chk($sformatf("rnd%0d_acc_cnt", n),   32'(acc_cnt),   32'(m_cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
